muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle for muldiv_unit: operation request, flush,
// direct hi/lo writes, and the busy/done/hi/lo result side.
interface muldiv_if #(
  parameter int size = 32
);
  logic            start;
  logic [1:0]      op;
  logic [size-1:0] a;
  logic [size-1:0] b;
  logic            flush;
  logic            wr_hi;
  logic            wr_lo;
  logic [size-1:0] wr_data;
  logic            busy;
  logic            done;
  logic [size-1:0] hi;
  logic [size-1:0] lo;

  modport master (
    output start, op, a, b, flush, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with hi/lo result registers (one bit per cycle).
// Define MULDIV_DIV_EN to compile in the restoring divider; otherwise div ops complete at once with hi/lo unchanged.
module muldiv_unit #(
  parameter int size = 32
) (
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  bus
);
  localparam int CW = (size > 1) ? $clog2(size) : 1;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
`ifdef MULDIV_DIV_EN
    DIV,
`endif
    FIX,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*size-1:0] prod;
  logic [size-1:0]   mcand;
  logic              neg_q;
  logic              busy_flag;
  logic              done_flag;
  logic [size-1:0]   hi_word;
  logic [size-1:0]   lo_word;
`ifdef MULDIV_DIV_EN
  logic              is_div;
  logic              neg_r;
  logic              b_zero;
  logic [size-1:0]   a_keep;
  logic [size:0]     shifted;
  logic [size:0]     trial;
`endif

  logic              sgn_a;
  logic              sgn_b;
  logic [size-1:0]   a_mag;
  logic [size-1:0]   b_mag;
  logic [size-1:0]   p_hi;
  logic [size-1:0]   p_lo;
  logic [size:0]     mul_sum;
  logic              start_acc;

  always_comb begin
    sgn_a     = ~bus.op[0] & bus.a[size-1];
    sgn_b     = ~bus.op[0] & bus.b[size-1];
    a_mag     = sgn_a ? -bus.a : bus.a;
    b_mag     = sgn_b ? -bus.b : bus.b;
    p_hi      = prod[2*size-1:size];
    p_lo      = prod[size-1:0];
    mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
    start_acc = bus.start & ~bus.flush & ((state == IDLE) | (state == DONE));
`ifdef MULDIV_DIV_EN
    // Remainder stays below the divisor, so bit size of trial is a clean borrow.
    shifted   = {p_hi, p_lo[size-1]};
    trial     = shifted - {1'b0, mcand};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      prod      <= '0;
      mcand     <= '0;
      neg_q     <= 1'b0;
      busy_flag <= 1'b0;
      done_flag <= 1'b0;
      hi_word   <= '0;
      lo_word   <= '0;
`ifdef MULDIV_DIV_EN
      is_div    <= 1'b0;
      neg_r     <= 1'b0;
      b_zero    <= 1'b0;
      a_keep    <= '0;
`endif
    end else begin
      done_flag <= 1'b0;
      if (bus.flush) begin
        state     <= IDLE;
        busy_flag <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start_acc) begin
              prod  <= {{size{1'b0}}, a_mag};
              mcand <= b_mag;
              neg_q <= sgn_a ^ sgn_b;
              cnt   <= CW'(size - 1);
              if (!bus.op[1]) begin
                state     <= MUL;
                busy_flag <= 1'b1;
`ifdef MULDIV_DIV_EN
                is_div    <= 1'b0;
`endif
              end else begin
`ifdef MULDIV_DIV_EN
                state     <= DIV;
                busy_flag <= 1'b1;
                is_div    <= 1'b1;
                neg_r     <= sgn_a;
                b_zero    <= (bus.b == '0);
                a_keep    <= bus.a;
`else
                state     <= DONE;
                done_flag <= 1'b1;
`endif
              end
            end else begin
              state <= IDLE;
            end
          end
          MUL: begin
            prod <= {mul_sum, p_lo[size-1:1]};
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - 1'b1;
          end
`ifdef MULDIV_DIV_EN
          DIV: begin
            if (!trial[size]) prod <= {trial[size-1:0], p_lo[size-2:0], 1'b1};
            else              prod <= {shifted[size-1:0], p_lo[size-2:0], 1'b0};
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - 1'b1;
          end
`endif
          FIX: begin
`ifdef MULDIV_DIV_EN
            if (is_div) begin
              if (b_zero) begin
                hi_word <= a_keep;
                lo_word <= '1;
              end else begin
                hi_word <= neg_r ? -p_hi : p_hi;
                lo_word <= neg_q ? -p_lo : p_lo;
              end
            end else
`endif
            {hi_word, lo_word} <= neg_q ? -prod : prod;
            state     <= DONE;
            busy_flag <= 1'b0;
            done_flag <= 1'b1;
          end
          default: begin
            state     <= IDLE;
            busy_flag <= 1'b0;
          end
        endcase
      end

      // busy_flag is low in FIX's own cycle only after its edge, so no clash with result load.
      if (!busy_flag && !start_acc) begin
        if (bus.wr_hi) hi_word <= bus.wr_data;
        if (bus.wr_lo) lo_word <= bus.wr_data;
      end
    end
  end

  assign bus.busy = busy_flag;
  assign bus.done = done_flag;
  assign bus.hi   = hi_word;
  assign bus.lo   = lo_word;
endmodule
